// File: rtl/counter_checker.sv
// Scoreboard for the universal up/down counter: tracks a reference model of the
// counter and records q / max_tick / min_tick mismatches.
module counter_checker #(
    parameter int unsigned N     = 3,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chk_en,
    input  logic             err_clr,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [N-1:0]     d,
    input  logic [N-1:0]     q,
    input  logic             max_tick,
    input  logic             min_tick,
    output logic             err_pulse,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       err_code,
    output logic [N-1:0]     first_q,
    output logic [N-1:0]     first_exp
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SYNC  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam logic [N-1:0]     Q_MAX   = '1;
    localparam logic [ERR_W-1:0] CNT_MAX = '1;

    logic [1:0]       state,         state_nxt;
    logic [N-1:0]     exp_q,         exp_q_nxt;
    logic             err_pulse_nxt;
    logic             err_flag_nxt;
    logic [ERR_W-1:0] err_cnt_nxt;
    logic [2:0]       err_code_nxt;
    logic [N-1:0]     first_q_nxt;
    logic [N-1:0]     first_exp_nxt;

    logic [N-1:0]     ref_next_c;
    logic [2:0]       mis_c;

    // Reference counter step taken from the observed q, so the model resyncs every edge.
    always_comb begin
        ref_next_c = q;
        if (clr) begin
            ref_next_c = '0;
        end else if (load) begin
            ref_next_c = d;
        end else if (en) begin
            ref_next_c = up ? q + N'(1) : q - N'(1);
        end
    end

    // Mismatch vector: bit0 q, bit1 max_tick, bit2 min_tick.
    assign mis_c = {min_tick != (q == '0), max_tick != (q == Q_MAX), q != exp_q};

    // Next-state and error bookkeeping.
    always_comb begin
        state_nxt     = state;
        exp_q_nxt     = exp_q;
        err_pulse_nxt = 1'b0;
        err_flag_nxt  = err_flag;
        err_cnt_nxt   = err_cnt;
        err_code_nxt  = err_code;
        first_q_nxt   = first_q;
        first_exp_nxt = first_exp;

        case (state)
            IDLE: begin
                if (chk_en) begin
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                exp_q_nxt = ref_next_c;
                state_nxt = chk_en ? CHECK : IDLE;
            end
            CHECK: begin
                exp_q_nxt = ref_next_c;
                if (|mis_c) begin
                    err_pulse_nxt = 1'b1;
                    err_flag_nxt  = 1'b1;
                    err_code_nxt  = mis_c;
                    if (err_cnt != CNT_MAX) begin
                        err_cnt_nxt = err_cnt + ERR_W'(1);
                    end
                    if (!err_flag) begin
                        first_q_nxt   = q;
                        first_exp_nxt = exp_q;
                    end
                end
                if (!chk_en) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Clear beats any mismatch on the same edge; FSM and model keep running.
        if (err_clr) begin
            err_pulse_nxt = 1'b0;
            err_flag_nxt  = 1'b0;
            err_cnt_nxt   = '0;
            err_code_nxt  = '0;
            first_q_nxt   = '0;
            first_exp_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            exp_q     <= '0;
            err_pulse <= 1'b0;
            err_flag  <= 1'b0;
            err_cnt   <= '0;
            err_code  <= '0;
            first_q   <= '0;
            first_exp <= '0;
        end else begin
            state     <= state_nxt;
            exp_q     <= exp_q_nxt;
            err_pulse <= err_pulse_nxt;
            err_flag  <= err_flag_nxt;
            err_cnt   <= err_cnt_nxt;
            err_code  <= err_code_nxt;
            first_q   <= first_q_nxt;
            first_exp <= first_exp_nxt;
        end
    end

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: the bench plays the observed counter and
// injects faults, comparing error outputs against hand-derived values.
module tb_counter_checker;

    logic       clk;
    logic       reset;
    logic       chk_en;
    logic       err_clr;
    logic       clr;
    logic       load;
    logic       en;
    logic       up;
    logic [2:0] d;
    logic [2:0] q;
    logic       max_tick;
    logic       min_tick;

    logic       err_pulse;
    logic       err_flag;
    logic [7:0] err_cnt;
    logic [2:0] err_code;
    logic [2:0] first_q;
    logic [2:0] first_exp;

    logic       s_err_pulse;
    logic       s_err_flag;
    logic [1:0] s_err_cnt;
    logic [2:0] s_err_code;
    logic [2:0] s_first_q;
    logic [2:0] s_first_exp;

    logic [18:0] obs;
    logic [18:0] want;
    int checks = 0;
    int errors = 0;

    assign obs = {err_pulse, err_flag, err_code, err_cnt, first_q, first_exp};

    counter_checker #(.N(3), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .chk_en(chk_en), .err_clr(err_clr),
        .clr(clr), .load(load), .en(en), .up(up), .d(d), .q(q),
        .max_tick(max_tick), .min_tick(min_tick),
        .err_pulse(err_pulse), .err_flag(err_flag), .err_cnt(err_cnt),
        .err_code(err_code), .first_q(first_q), .first_exp(first_exp)
    );

    counter_checker #(.N(3), .ERR_W(2)) dut_s (
        .clk(clk), .reset(reset), .chk_en(chk_en), .err_clr(err_clr),
        .clr(clr), .load(load), .en(en), .up(up), .d(d), .q(q),
        .max_tick(max_tick), .min_tick(min_tick),
        .err_pulse(s_err_pulse), .err_flag(s_err_flag), .err_cnt(s_err_cnt),
        .err_code(s_err_code), .first_q(s_first_q), .first_exp(s_first_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] pk(input logic p, input logic f, input logic [2:0] c,
                                       input logic [7:0] n, input logic [2:0] fq,
                                       input logic [2:0] fe);
        return {p, f, c, n, fq, fe};
    endfunction

    // Correct behaviour of the observed counter, used to drive its q.
    function automatic logic [2:0] cnt_next(input logic [2:0] v);
        logic [2:0] r;
        r = v;
        if (clr)       r = 3'd0;
        else if (load) r = d;
        else if (en)   r = up ? v + 3'd1 : v - 3'd1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_q(input logic [2:0] v);
        q        = v;
        max_tick = (v == 3'd7);
        min_tick = (v == 3'd0);
    endtask

    task automatic step();
        logic [2:0] nq;
        nq = cnt_next(q);
        tick();
        set_q(nq);
    endtask

    task automatic clr_errors();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; chk_en = 1'b0; err_clr = 1'b0;
        clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; d = 3'd0;
        set_q(3'd0);
        #6;
        checks++;
        if (obs !== 19'd0) begin errors++; $display("FAIL reset_state: got %h want %h", obs, 19'd0); end
        checks++;
        if ({s_err_flag, s_err_cnt} !== 3'd0) begin errors++; $display("FAIL reset_sat: got %h want 0", {s_err_flag, s_err_cnt}); end
        #4 reset = 1'b1;
        tick();
        checks++;
        if (obs !== 19'd0) begin errors++; $display("FAIL idle_hold: got %h want %h", obs, 19'd0); end
    endtask

    task automatic test_count();
        chk_en = 1'b1; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (err_pulse !== 1'b0) begin errors++; $display("FAIL count_pulse[%0d]: got %b want 0", i, err_pulse); end
        end
        checks++;
        if (obs !== 19'd0) begin errors++; $display("FAIL count_final: got %h want %h", obs, 19'd0); end
    endtask

    task automatic test_stuck();
        load = 1'b1; d = 3'd2;
        step();
        load = 1'b0;
        step();
        tick();
        checks++;
        if (err_pulse !== 1'b0) begin errors++; $display("FAIL stuck_pre: got %b want 0", err_pulse); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            want = pk(1'b1, 1'b1, 3'b001, 8'(i), 3'd3, 3'd4);
            checks++;
            if (obs !== want) begin errors++; $display("FAIL stuck_err[%0d]: got %h want %h", i, obs, want); end
        end
        set_q(3'd4);
        step();
        want = pk(1'b0, 1'b1, 3'b001, 8'd3, 3'd3, 3'd4);
        checks++;
        if (obs !== want) begin errors++; $display("FAIL stuck_recover: got %h want %h", obs, want); end
        clr_errors();
        checks++;
        if (obs !== 19'd0) begin errors++; $display("FAIL stuck_clear: got %h want %h", obs, 19'd0); end
    endtask

    task automatic test_max_tick();
        load = 1'b1; d = 3'd5;
        step();
        load = 1'b0;
        step();
        step();
        max_tick = 1'b0;
        step();
        want = pk(1'b1, 1'b1, 3'b010, 8'd1, 3'd7, 3'd7);
        checks++;
        if (obs !== want) begin errors++; $display("FAIL max_err: got %h want %h", obs, want); end
        step();
        want = pk(1'b0, 1'b1, 3'b010, 8'd1, 3'd7, 3'd7);
        checks++;
        if (obs !== want) begin errors++; $display("FAIL max_after: got %h want %h", obs, want); end
        clr_errors();
    endtask

    task automatic test_clr_load();
        clr = 1'b1; load = 1'b1; d = 3'd5;
        step();
        clr = 1'b0; load = 1'b0; en = 1'b0;
        tick();
        checks++;
        if (obs !== 19'd0) begin errors++; $display("FAIL clr_prio_ok: got %h want %h", obs, 19'd0); end
        clr = 1'b1; load = 1'b1;
        tick();
        set_q(3'd5);
        clr = 1'b0; load = 1'b0;
        tick();
        want = pk(1'b1, 1'b1, 3'b001, 8'd1, 3'd5, 3'd0);
        checks++;
        if (obs !== want) begin errors++; $display("FAIL clr_prio_bad: got %h want %h", obs, want); end
        tick();
        want = pk(1'b0, 1'b1, 3'b001, 8'd1, 3'd5, 3'd0);
        checks++;
        if (obs !== want) begin errors++; $display("FAIL clr_prio_hold: got %h want %h", obs, want); end
        clr_errors();
    endtask

    task automatic test_down_errclr();
        load = 1'b1; d = 3'd1;
        step();
        load = 1'b0; en = 1'b1; up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (err_pulse !== 1'b0) begin errors++; $display("FAIL down_pulse[%0d]: got %b want 0", i, err_pulse); end
        end
        checks++;
        if (obs !== 19'd0) begin errors++; $display("FAIL down_wrap: got %h want %h", obs, 19'd0); end
        set_q(3'd2);
        err_clr = 1'b1;
        tick();
        set_q(3'd1);
        err_clr = 1'b0;
        checks++;
        if (obs !== 19'd0) begin errors++; $display("FAIL errclr_wins: got %h want %h", obs, 19'd0); end
        step();
        checks++;
        if (obs !== 19'd0) begin errors++; $display("FAIL errclr_after: got %h want %h", obs, 19'd0); end
    endtask

    task automatic test_saturate_reset();
        logic [1:0] s_want;
        clr_errors();
        up = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            s_want = (t - 1 >= 3) ? 2'd3 : 2'(t - 1);
            checks++;
            if (s_err_cnt !== s_want) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", t, s_err_cnt, s_want); end
        end
        want = pk(1'b1, 1'b1, 3'b001, 8'd6, 3'd7, 3'd0);
        checks++;
        if (obs !== want) begin errors++; $display("FAIL sat_wide: got %h want %h", obs, want); end
        checks++;
        if (s_err_flag !== 1'b1) begin errors++; $display("FAIL sat_flag: got %b want 1", s_err_flag); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs !== 19'd0) begin errors++; $display("FAIL midrun_reset: got %h want %h", obs, 19'd0); end
        checks++;
        if ({s_err_pulse, s_err_flag, s_err_cnt} !== 4'd0) begin errors++; $display("FAIL midrun_reset_s: got %h want 0", {s_err_pulse, s_err_flag, s_err_cnt}); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== 19'd0) begin errors++; $display("FAIL resync[%0d]: got %h want %h", i, obs, 19'd0); end
        end
        tick();
        want = pk(1'b1, 1'b1, 3'b001, 8'd1, 3'd7, 3'd0);
        checks++;
        if (obs !== want) begin errors++; $display("FAIL resync_check: got %h want %h", obs, want); end
    endtask

    task automatic test_idle_hold();
        chk_en = 1'b0;
        tick();
        want = pk(1'b1, 1'b1, 3'b001, 8'd2, 3'd7, 3'd0);
        checks++;
        if (obs !== want) begin errors++; $display("FAIL exit_compare: got %h want %h", obs, want); end
        for (int i = 0; i < 2; i++) begin
            tick();
            want = pk(1'b0, 1'b1, 3'b001, 8'd2, 3'd7, 3'd0);
            checks++;
            if (obs !== want) begin errors++; $display("FAIL idle_hold[%0d]: got %h want %h", i, obs, want); end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_stuck();
        test_max_tick();
        test_clr_load();
        test_down_errclr();
        test_saturate_reset();
        test_idle_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Hardware scoreboard sitting alongside the universal up/down counter (clr/load/en/up/d in; q, max_tick, min_tick out).
- Observes the counter's control inputs and outputs every clock, runs an independent reference model, and flags any q or tick mismatch.
- Reports mismatches through a sticky flag, a saturating error count and a first-error capture, so lab benches and on-board builds get self-checking without waveform inspection.

Parameters:
- N, 3, counter width; must match the observed counter.
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  clock shared with the observed counter.
- reset  in  1  asynchronous, active-low.
- chk_en  in  1  enables checking; low = idle.
- err_clr  in  1  synchronous clear of all error state.
- clr  in  1  observed counter synchronous clear.
- load  in  1  observed counter parallel load.
- en  in  1  observed counter count enable.
- up  in  1  observed direction; 1 = up.
- d  in  N  observed load data.
- q  in  N  observed counter value.
- max_tick  in  1  observed max indicator.
- min_tick  in  1  observed min indicator.
- err_pulse  out  1  one-cycle pulse per detected mismatch.
- err_flag  out  1  sticky error indicator.
- err_cnt  out  ERR_W  saturating mismatch count.
- err_code  out  3  cause of the last mismatch: bit0 = q, bit1 = max_tick, bit2 = min_tick.
- first_q  out  N  observed q at the first mismatch.
- first_exp  out  N  expected q at the first mismatch.

Behaviour:
- Reset (reset=0, async): state=IDLE; exp_q=0; err_pulse=0; err_flag=0; err_cnt=0; err_code=0; first_q=0; first_exp=0.
- Reference counter semantics, evaluated per posedge with priority clr > load > en:
  - clr: next = 0.
  - load: next = d.
  - en&up: next = q+1, mod 2^N (7 -> 0 for N=3).
  - en&~up: next = q-1, mod 2^N (0 -> 7).
  - otherwise: hold.
  - max_tick is combinational: (q == 2^N-1). min_tick is combinational: (q == 0).
- FSM:
  - IDLE: no compares. chk_en=1 -> SYNC.
  - SYNC, one cycle: exp_q <= next(q, controls); no compare -> CHECK. chk_en=0 -> IDLE.
  - CHECK, each posedge:
    - Compare q with exp_q.
    - Compare max_tick with (q==2^N-1).
    - Compare min_tick with (q==0).
    - Then exp_q <= next(q, controls). The model resyncs to observed q, so one fault produces one error, not a cascade.
    - chk_en=0 -> IDLE; the compare on that edge still occurs.
- Mismatch at edge k (any of the three compares fails):
  - At edge k: err_pulse=1 for exactly one cycle.
  - err_code = mismatch bits.
  - err_flag=1.
  - err_cnt+1, saturating at 2^ERR_W-1.
  - first_q/first_exp latched only if err_flag was 0 before edge k.
- No mismatch: err_pulse=0; err_code holds its last value.
- err_clr=1 at a posedge:
  - err_flag, err_cnt, err_code, first_q, first_exp and err_pulse are cleared.
  - err_clr wins over a simultaneous mismatch; that mismatch is discarded.
  - FSM and exp_q are unaffected.
- Error outputs hold their values in IDLE.
- Reset mid-CHECK returns the block to IDLE with all outputs cleared. After release, a fresh SYNC is required.
- Counter inputs are assumed synchronous to clk; no metastability handling.

Test Plan:
- Reset low 10 ns, then chk_en=1, en=1, up=1 for 10 cycles on a correct N=3 counter (q 0..7,0,1) -> err_flag=0, err_cnt=0, wrap 7->0 accepted.
- Force q stuck at 3 while up-counting from 2 -> one err_pulse per cycle, err_code=3'b001; first_q=3, first_exp=4; err_cnt increments each cycle.
- Counter with max_tick tied 0, counting past 7 -> err_code=3'b010 at q=7, err_cnt=1; no q errors.
- load=1, d=5 with clr=1 on the same cycle, correct DUT yields q=0 -> no error; mismatch reported only if the DUT yields 5 (first_q=5, first_exp=0).
- Down count from 1 with en=1, up=0 -> 0 then 7 accepted; err_clr asserted together with an injected fault -> err_cnt=0, err_flag=0 afterwards.
- ERR_W=2 with a persistent fault for 6 cycles -> err_cnt saturates at 3; async reset mid-run clears everything; checking resumes only after SYNC.
